// File: rtl/axi_wbeat_addr_gen_if.sv
// AW-command in / per-beat write-address out bundle for axi_wbeat_addr_gen.
// The master drives commands and takes beats; the slave is the generator.
interface axi_wbeat_addr_gen_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic          beat_valid;
    logic          beat_ready;
    logic [AW-1:0] beat_addr;
    logic [7:0]    beat_idx;
    logic          beat_last;
    logic [3:0]    cmd_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_idx, beat_last, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_idx, beat_last, cmd_err
    );
endinterface

// File: rtl/axi_wbeat_addr_gen.sv
// Expands one AW command into per-beat addresses with last flag and error flags.
// Beat 0 appears the cycle after accept; beats freeze while beat_ready is low.
module axi_wbeat_addr_gen #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic                  axi_aclk,
    input  logic                  rst_n,
    axi_wbeat_addr_gen_if.slave   bus
);
    localparam int          EW       = AW + 9;
    localparam logic [2:0]  MAX_SIZE = 3'($clog2(DW / 8));
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  BURST_RSVD  = 2'b11;
    localparam logic [EW-1:0] PAGE_MASK = {{9{1'b0}}, {(AW-12){1'b1}}, 12'h000};

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] lower_q, lower_d;
    logic [AW-1:0] wrap_w_q, wrap_w_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    rem_q, rem_d;
    logic          last_q, last_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic [3:0]    err_q, err_d;

    logic          beat_take;
    logic          cmd_take;
    logic          wrap_len_ok;
    logic [1:0]    new_burst;
    logic [3:0]    new_err;
    logic [EW-1:0] new_bytes;
    logic [EW-1:0] new_end;
    logic [AW-1:0] new_w;
    logic [AW-1:0] b_cur;
    logic [AW-1:0] a_inc;
    logic [AW-1:0] next_addr;

    assign bus.beat_valid = (state_q == ST_BURST);
    assign bus.beat_addr  = addr_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = last_q;
    assign bus.cmd_err    = err_q;

    assign beat_take     = bus.beat_valid && bus.beat_ready;
    assign bus.cmd_ready = (state_q == ST_IDLE) || (beat_take && last_q);
    assign cmd_take      = bus.cmd_valid && bus.cmd_ready;

    // Command decode: total burst bytes and end address are kept wide so a
    // burst running past the top of the address space still shows as a crossing.
    always_comb begin
        wrap_len_ok = (bus.cmd_len == 8'd1) || (bus.cmd_len == 8'd3) ||
                      (bus.cmd_len == 8'd7) || (bus.cmd_len == 8'd15);
        new_bytes   = EW'({1'b0, bus.cmd_len} + 9'd1) << bus.cmd_size;
        new_end     = {9'b0, bus.cmd_addr} + new_bytes - EW'(1);
        new_w       = new_bytes[AW-1:0];
        new_burst   = bus.cmd_burst;
        new_err     = 4'b0000;
        if (bus.cmd_burst == BURST_RSVD) begin
            new_burst  = BURST_INCR;
            new_err[0] = 1'b1;
        end else if ((bus.cmd_burst == BURST_WRAP) && !wrap_len_ok) begin
            new_burst  = BURST_INCR;
            new_err[1] = 1'b1;
        end
        new_err[2] = (new_burst == BURST_INCR) &&
                     (|(({9'b0, bus.cmd_addr} ^ new_end) & PAGE_MASK));
        new_err[3] = (bus.cmd_size > MAX_SIZE);
    end

    // Next beat address from the aligned current address.
    always_comb begin
        b_cur = AW'(1) << size_q;
        a_inc = (addr_q & ~(b_cur - AW'(1))) + b_cur;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (a_inc == (lower_q + wrap_w_q)) ? lower_q : a_inc;
            default:     next_addr = a_inc;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lower_d  = lower_q;
        wrap_w_d = wrap_w_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        last_d   = last_q;
        size_d   = size_q;
        burst_d  = burst_q;
        err_d    = err_q;
        if (cmd_take) begin
            state_d  = ST_BURST;
            addr_d   = bus.cmd_addr;
            lower_d  = bus.cmd_addr & ~(new_w - AW'(1));
            wrap_w_d = new_w;
            idx_d    = 8'd0;
            rem_d    = bus.cmd_len;
            last_d   = (bus.cmd_len == 8'd0);
            size_d   = bus.cmd_size;
            burst_d  = new_burst;
            err_d    = new_err;
        end else if (beat_take) begin
            if (last_q) begin
                state_d = ST_IDLE;
                err_d   = 4'b0000;
            end else begin
                addr_d = next_addr;
                idx_d  = idx_q + 8'd1;
                rem_d  = rem_q - 8'd1;
                last_d = (rem_q == 8'd1);
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            lower_q  <= '0;
            wrap_w_q <= '0;
            idx_q    <= 8'd0;
            rem_q    <= 8'd0;
            last_q   <= 1'b0;
            size_q   <= 3'd0;
            burst_q  <= BURST_FIXED;
            err_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lower_q  <= lower_d;
            wrap_w_q <= wrap_w_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            last_q   <= last_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_wbeat_addr_gen.sv
// Bench for axi_wbeat_addr_gen: directed and random commands against a burst
// expansion model; beats compared in order, cmd_ready checked every cycle.
module tb_axi_wbeat_addr_gen;
    localparam int AW = 32;

    logic axi_aclk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    axi_wbeat_addr_gen_if #(.AW(AW)) bus ();

    axi_wbeat_addr_gen #(.AW(AW), .DW(64)) dut (
        .axi_aclk (axi_aclk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } cmd_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  idx;
        bit          last;
        logic [3:0]  err;
    } beat_t;

    cmd_t        cmd_q[$];
    beat_t       exp_q[$];
    logic [31:0] log_addr[$];
    logic [3:0]  log_err[$];
    int          n_chk   = 0;
    int          n_fail  = 0;
    bit          holding = 1'b0;

    logic [31:0] dir_addr [23] = '{
        32'h1004, 32'h1008, 32'h100C, 32'h1010,
        32'h1006, 32'h1008, 32'h100C,
        32'h3000, 32'h3000, 32'h3000,
        32'h2038, 32'h2020, 32'h2028, 32'h2030,
        32'h2038, 32'h2040, 32'h2048,
        32'h0FF8, 32'h1000,
        32'h1000, 32'h1004,
        32'h0040, 32'h0080};
    logic [3:0] dir_err [23] = '{
        4'h0, 4'h0, 4'h0, 4'h0,
        4'h0, 4'h0, 4'h0,
        4'h0, 4'h0, 4'h0,
        4'h0, 4'h0, 4'h0, 4'h0,
        4'h2, 4'h2, 4'h2,
        4'h4, 4'h4,
        4'h1, 4'h1,
        4'h0, 4'h0};

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Burst rules applied directly: beat i address from start, size and count.
    function automatic void expand(input cmd_t c);
        longint unsigned start = longint'(c.addr);
        longint unsigned b     = 64'd1 << c.size;
        longint unsigned n     = longint'(c.len) + 1;
        longint unsigned w, lower, a0, a, last_byte;
        logic [3:0] err = 4'h0;
        int eb = int'(c.burst);
        beat_t bt;
        if (c.burst == 2'b11) begin
            eb = 1; err[0] = 1'b1;
        end else if (c.burst == 2'b10 && !(c.len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            eb = 1; err[1] = 1'b1;
        end
        last_byte = start + b * n - 1;
        if (eb == 1 && ((start >> 12) & 64'hFFFFF) != ((last_byte >> 12) & 64'hFFFFF))
            err[2] = 1'b1;
        if (c.size > 3'd3) err[3] = 1'b1;
        w     = b * n;
        lower = start & ~(w - 1);
        a0    = start & ~(b - 1);
        for (int i = 0; i < int'(n); i++) begin
            if (i == 0 || eb == 0) a = start;
            else if (eb == 1)      a = a0 + longint'(i) * b;
            else                   a = lower + ((a0 - lower + longint'(i) * b) % w);
            bt.addr = a[31:0];
            bt.idx  = 8'(i);
            bt.last = (i == int'(n) - 1);
            bt.err  = err;
            exp_q.push_back(bt);
        end
    endfunction

    task automatic step(input bit rdy, input bit offer);
        bit exp_rdy;
        @(negedge axi_aclk);
        chk_val("beat_valid", 64'(bus.beat_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk_val("beat_addr", 64'(bus.beat_addr), 64'(exp_q[0].addr));
            chk_val("beat_idx",  64'(bus.beat_idx),  64'(exp_q[0].idx));
            chk_val("beat_last", 64'(bus.beat_last), 64'(exp_q[0].last));
            chk_val("cmd_err",   64'(bus.cmd_err),   64'(exp_q[0].err));
        end else begin
            chk_val("idle_err",  64'(bus.cmd_err),   64'(0));
        end
        bus.beat_ready = rdy;
        if (!holding && cmd_q.size() != 0 && offer) holding = 1'b1;
        bus.cmd_valid = holding;
        if (holding) begin
            bus.cmd_addr  = cmd_q[0].addr;
            bus.cmd_len   = cmd_q[0].len;
            bus.cmd_size  = cmd_q[0].size;
            bus.cmd_burst = cmd_q[0].burst;
        end
        #1;
        exp_rdy = (exp_q.size() == 0) || (exp_q[0].last && rdy);
        chk_val("cmd_ready", 64'(bus.cmd_ready), 64'(exp_rdy));
        if (exp_q.size() != 0 && rdy) begin
            log_addr.push_back(bus.beat_addr);
            log_err.push_back(bus.cmd_err);
            void'(exp_q.pop_front());
        end
        if (holding && exp_rdy) begin
            expand(cmd_q.pop_front());
            holding = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int budget, input int rdy_pct, input int offer_pct);
        int cyc = 0;
        while ((cmd_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            step($urandom_range(99, 0) < rdy_pct, $urandom_range(99, 0) < offer_pct);
            cyc++;
        end
        chk_val(tag, 64'(cmd_q.size() + exp_q.size()), 64'(0));
    endtask

    initial begin
        cmd_t c;
        int   r;
        logic [31:0] ra;
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = 8'd0;
        bus.cmd_size   = 3'd0;
        bus.cmd_burst  = 2'b00;
        bus.beat_ready = 1'b0;
        #2;
        chk_val("rst_valid", 64'(bus.beat_valid), 64'(0));
        chk_val("rst_ready", 64'(bus.cmd_ready),  64'(1));
        chk_val("rst_err",   64'(bus.cmd_err),    64'(0));
        chk_val("rst_addr",  64'(bus.beat_addr),  64'(0));
        chk_val("rst_idx",   64'(bus.beat_idx),   64'(0));
        chk_val("rst_last",  64'(bus.beat_last),  64'(0));
        #10 rst_n = 1'b1;

        // Directed bursts, all held valid back-to-back; stall on cycles 2..4.
        cmd_q.push_back('{32'h1004, 8'd3, 3'd2, 2'b01});
        cmd_q.push_back('{32'h1006, 8'd2, 3'd2, 2'b01});
        cmd_q.push_back('{32'h3000, 8'd2, 3'd2, 2'b00});
        cmd_q.push_back('{32'h2038, 8'd3, 3'd3, 2'b10});
        cmd_q.push_back('{32'h2038, 8'd2, 3'd3, 2'b10});
        cmd_q.push_back('{32'h0FF8, 8'd1, 3'd3, 2'b01});
        cmd_q.push_back('{32'h1000, 8'd1, 3'd2, 2'b11});
        cmd_q.push_back('{32'h0040, 8'd0, 3'd2, 2'b01});
        cmd_q.push_back('{32'h0080, 8'd0, 3'd2, 2'b01});
        log_addr.delete();
        log_err.delete();
        for (int cyc = 0; cyc < 200 && (cmd_q.size() != 0 || exp_q.size() != 0); cyc++)
            step(!(cyc inside {2, 3, 4}), 1'b1);
        chk_val("dir_drain", 64'(cmd_q.size() + exp_q.size()), 64'(0));
        chk_val("dir_nbeats", 64'(log_addr.size()), 64'(23));
        for (int i = 0; i < 23 && i < log_addr.size(); i++) begin
            chk_val($sformatf("dir_addr[%0d]", i), 64'(log_addr[i]), 64'(dir_addr[i]));
            chk_val($sformatf("dir_err[%0d]", i),  64'(log_err[i]),  64'(dir_err[i]));
        end

        // 256-beat burst running off the top of the address space.
        cmd_q.push_back('{32'hFFFF_FF80, 8'd255, 3'd0, 2'b01});
        drain("len255_drain", 400, 100, 100);

        // Reset in the middle of a burst.
        cmd_q.push_back('{32'h5000, 8'd15, 3'd2, 2'b01});
        repeat (4) step(1'b1, 1'b1);
        @(negedge axi_aclk);
        #2 rst_n = 1'b0;
        #1;
        chk_val("mid_rst_valid", 64'(bus.beat_valid), 64'(0));
        chk_val("mid_rst_ready", 64'(bus.cmd_ready),  64'(1));
        chk_val("mid_rst_err",   64'(bus.cmd_err),    64'(0));
        exp_q.delete();
        cmd_q.delete();
        holding       = 1'b0;
        bus.cmd_valid = 1'b0;
        @(posedge axi_aclk);
        #2 rst_n = 1'b1;
        chk_val("post_rst_ready", 64'(bus.cmd_ready), 64'(1));
        repeat (3) step(1'b1, 1'b0);

        // Random commands with random backpressure and offer gaps.
        for (int k = 0; k < 300; k++) begin
            ra = $urandom;
            r  = $urandom_range(1, 0);
            c.addr = (r == 0) ? ra : {ra[31:12], 4'hF, ra[7:0]};
            r = $urandom_range(7, 0);
            case (r)
                0: c.len = 8'd0;
                1: c.len = 8'd1;
                2: c.len = 8'd3;
                3: c.len = 8'd7;
                4: c.len = 8'd15;
                5: c.len = 8'd2;
                6: c.len = 8'($urandom_range(31, 0));
                default: c.len = 8'($urandom_range(255, 0));
            endcase
            c.size  = 3'($urandom_range(7, 0));
            c.burst = 2'($urandom_range(3, 0));
            cmd_q.push_back(c);
        end
        drain("rand_drain", 30000, 70, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wbeat_addr_gen.md
# axi_wbeat_addr_gen

Per-beat write-address generator placed directly downstream of the AXI write-address channel FSM. It accepts one committed AW command (address, length, size, burst type) per handshake and expands it into a stream of beat addresses, one per W-channel beat, each with a last flag. It also flags protocol-illegal commands. The W-data path and any memory-side model consume its beat stream.

## Interface
- AW, default 32: address width.
- DW, default 64: data bus width in bits; bus bytes = DW/8.
- axi_aclk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  AW command offered; connected to the AW commit.
- cmd_ready  out  1  generator can take a command.
- cmd_addr  in  AW  start address.
- cmd_len  in  8  beats minus one.
- cmd_size  in  3  log2 of bytes per beat.
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid  out  1  beat address valid.
- beat_ready  in  1  consumer takes the beat; connected to the W commit.
- beat_addr  out  AW  byte address of the current beat.
- beat_idx  out  8  beat number, 0-based.
- beat_last  out  1  current beat is the final beat.
- cmd_err  out  4  error flags for the active burst: [0] reserved burst, [1] illegal WRAP length, [2] INCR 4 KB crossing, [3] size > log2(DW/8).

## Operation
- States: IDLE and BURST. cmd_ready = (state==IDLE) || (beat_valid && beat_ready && beat_last). This is combinational, so back-to-back bursts have no bubble.
- Accept (cmd_valid && cmd_ready):
  - Go to BURST and assert beat_valid.
  - Load beat_addr=cmd_addr, beat_idx=0, remaining=cmd_len, beat_last=(cmd_len==0).
  - Latch size, effective burst and wrap bounds.
  - Compute cmd_err from the command and hold it for the whole burst.
- Effective burst:
  - Reserved (11) is handled as INCR and sets err[0].
  - WRAP with cmd_len not in {1,3,7,15} is handled as INCR and sets err[1].
- Beat advance (beat_valid && beat_ready, not last): beat_idx+1, remaining-1, beat_last=(remaining==1).
- Next beat_addr, with B = 1<<size and A = beat_addr & ~(B-1):
  - FIXED: unchanged.
  - INCR: A+B. An unaligned first address aligns from beat 1.
  - WRAP: W = B*(len+1) and lower = start & ~(W-1), both latched at accept. next = A+B, except next == lower+W gives lower.
- All arithmetic is modulo 2^AW; no saturation.
- err[2] is set when effective INCR and start[AW-1:12] != (start + B*(len+1) - 1)[AW-1:12]. The end address is computed at AW+9 bits.
- err[3] is set when cmd_size > log2(DW/8). Beats are still generated using the given size.
- Errors never stop or alter beat generation beyond the effective-burst substitution above.
- Last beat taken:
  - With a new command accepted the same cycle, load it as above.
  - Otherwise go to IDLE, clear beat_valid and zero cmd_err.

## Timing
- Reset values, applied immediately on rst_n low: beat_valid=0, beat_addr=0, beat_idx=0, beat_last=0, cmd_err=0, state IDLE. cmd_ready is therefore 1.
- Reset mid-burst drops the burst; there is no residual beat after release.
- Latency: command accepted at edge T gives beat_valid high with beat 0 after T.
- Each taken beat presents the next beat after that same edge, so one beat per cycle is possible.
- beat_valid, beat_addr, beat_idx, beat_last and cmd_err are stable while beat_valid && !beat_ready.
- cmd_valid while busy and not on the last handshake: the command is not taken. The upstream holds it.
- Burst of 256 beats (len=255): beat_idx reaches 255 with no overflow.

## Test plan
- INCR: addr 0x1004, size 2, len 3, beat_ready=1 -> 0x1004, 0x1008, 0x100C, 0x1010 on consecutive cycles, last on idx 3, cmd_err=0.
- Unaligned INCR and FIXED:
  - 0x1006, size 2, len 2 -> 0x1006, 0x1008, 0x100C.
  - FIXED 0x3000, len 2 -> 0x3000 three times.
- WRAP: 0x2038, size 3, len 3 -> 0x2038, 0x2020, 0x2028, 0x2030, last on the 4th beat.
- WRAP len 2 at 0x2038, size 3 -> INCR addresses 0x2038, 0x2040, 0x2048, err[1]=1.
- 4 KB crossing: 0x0FF8, size 3, len 1 -> 0x0FF8, 0x1000, cmd_err=0100. Reserved burst 11 -> err[0], INCR addresses.
- Back-to-back: two len-0 commands held valid -> beats on consecutive cycles, cmd_ready high on the last handshake.
  - Stall: beat_ready low 3 cycles -> outputs frozen.
  - rst_n low mid-burst -> beat_valid drops at once; after release cmd_ready=1.
